// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite responder with a bank of 32-bit read/write registers
// Write and read channels run independent FSMs with one outstanding transaction each.
module axi_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h10)
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int                    STRB_W    = DATA_WIDTH / 8;
  localparam int                    IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * NUM_REGS);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic f_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WIN_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  wstate_t               r_wstate, w_wstate_nxt;
  logic                  r_awready, r_wready, r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs, w_w_hs, w_aw_have, w_w_have;
  logic                  w_commit, w_b_done, w_ar_hs, w_r_done;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_wr_hit;
  logic [IDX_W-1:0]      w_wr_idx;

  assign w_aw_hs   = awvalid && r_awready;
  assign w_w_hs    = wvalid && r_wready;
  assign w_aw_have = w_aw_hs || r_aw_held;
  assign w_w_have  = w_w_hs || r_w_held;
  assign w_ar_hs   = arvalid && r_arready;

  // Whichever half arrives on the commit edge is taken straight from the bus.
  assign w_wr_addr = r_aw_held ? r_awaddr : awaddr;
  assign w_wr_data = r_w_held ? r_wdata : wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : wstrb;
  assign w_wr_hit  = f_hit(w_wr_addr);
  assign w_wr_idx  = f_idx(w_wr_addr);

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    w_b_done     = 1'b0;
    case (r_wstate)
      W_IDLE: if (w_aw_have && w_w_have) begin
        w_commit     = 1'b1;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: if (bready) begin
        w_b_done     = 1'b1;
        w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (r_wstate == W_IDLE) begin
        r_awready <= !w_aw_have;
        r_wready  <= !w_w_have;
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= wdata;
          r_wstrb  <= wstrb;
        end
        if (w_commit) begin
          r_aw_held <= 1'b0;
          r_w_held  <= 1'b0;
          r_bvalid  <= 1'b1;
          r_bresp   <= w_wr_hit ? 2'b00 : 2'b10;
          if (w_wr_hit) begin
            for (int k = 0; k < STRB_W; k++)
              if (w_wr_strb[k]) r_regs[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
          end
        end
      end else if (w_b_done) begin
        r_bvalid  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_r_done     = 1'b0;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA: if (rready) begin
        w_r_done     = 1'b1;
        w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Reads sample r_regs before any same-edge write lands, so they see the old value.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (r_rstate == R_IDLE) begin
        r_arready <= !w_ar_hs;
        if (w_ar_hs) begin
          r_rvalid <= 1'b1;
          r_rresp  <= f_hit(araddr) ? 2'b00 : 2'b10;
          r_rdata  <= f_hit(araddr) ? r_regs[f_idx(araddr)] : '0;
        end
      end else if (w_r_done) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
    assign reg_q[DATA_WIDTH*gi +: DATA_WIDTH] = r_regs[gi];
  end

endmodule
